// File: rtl/tdm_rr_scheduler.sv
// Round-robin TDM scheduler for a shared 4:1 mux / 1:4 demux single-wire channel.
// Grants one requester at a time for at most BURST cycles, with a dead GUARD cycle between owners.
module tdm_rr_scheduler #(
   parameter int BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] a,
   output logic [1:0] s,
   output logic [3:0] gnt,
   output logic       busy,
   output logic [3:0] g
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

   state_t     state, state_nxt;
   logic [1:0] owner, owner_nxt;
   logic [1:0] last, last_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] gnt_nxt;
   logic       busy_nxt;
   logic [1:0] rr_sel;

   // Search order last+1, last+2, last+3, last: the previous owner has lowest priority
   // but is still chosen when it is the only requester.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = l;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = l + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = cnt;
      rr_sel    = rr_pick(req, last);

      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               owner_nxt = rr_sel;
               last_nxt  = rr_sel;
               cnt_nxt   = 4'd0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // The cycle in which the drop or burst end is sampled still carries the grant.
            if (!req[owner] || cnt == CNT_MAX) begin
               state_nxt = GUARD;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         GUARD: begin
            if (req != 4'b0000) begin
               owner_nxt = rr_sel;
               last_nxt  = rr_sel;
               cnt_nxt   = 4'd0;
               state_nxt = GRANT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      gnt_nxt  = (state_nxt == GRANT) ? (4'b0001 << owner_nxt) : 4'b0000;
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 2'd0;
         last  <= 2'd3;
         cnt   <= 4'd0;
         gnt   <= 4'b0000;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         busy  <= busy_nxt;
      end
   end

   assign s = owner;

   // Demux gating: only the granted lane ever sees the selected source bit.
   assign g = gnt & {4{a[s]}};

endmodule

// File: tb/tb_tdm_rr_scheduler.sv
// Bench for tdm_rr_scheduler: burst-level reference model, per-cycle compare, directed and random stimulus.
module tb_tdm_rr_scheduler;

   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] a;
   logic [1:0] s;
   logic [3:0] gnt;
   logic       busy;
   logic [3:0] g;

   int total = 0;
   int bad   = 0;

   tdm_rr_scheduler #(.BURST(BURST)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .a    (a),
      .s    (s),
      .gnt  (gnt),
      .busy (busy),
      .g    (g)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: phase 0 = idle, 1 = granted, 2 = guard; run = cycles granted in this burst.
   function automatic int pick(input logic [3:0] r, input int l);
      for (int k = 1; k <= 4; k++) begin
         if (r[(l + k) % 4]) return (l + k) % 4;
      end
      return -1;
   endfunction

   int   m_phase = 0;
   int   m_owner = 0;
   int   m_last  = 3;
   int   m_run   = 0;
   bit   m_valid = 1'b0;
   logic [3:0] m_gnt;
   logic [1:0] m_s;
   logic       m_busy;

   assign m_gnt  = (m_phase == 1) ? 4'(1 << m_owner) : 4'h0;
   assign m_s    = 2'(m_owner);
   assign m_busy = (m_phase != 0);

   always @(posedge clk) begin : model
      int ph, ow, la, rn, p;
      ph = m_phase; ow = m_owner; la = m_last; rn = m_run;
      if (rst) begin
         ph = 0; ow = 0; la = 3; rn = 0;
      end else begin
         case (ph)
            0: begin
               p = pick(req, la);
               if (p >= 0) begin ph = 1; ow = p; la = p; rn = 1; end
            end
            1: begin
               if (!req[ow] || rn == BURST) ph = 2;
               else rn = rn + 1;
            end
            default: begin
               p = pick(req, la);
               if (p >= 0) begin ph = 1; ow = p; la = p; rn = 1; end
               else ph = 0;
            end
         endcase
      end
      m_phase <= ph;
      m_owner <= ow;
      m_last  <= la;
      m_run   <= rn;
      if (rst) m_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("gnt",  gnt,  m_gnt);
         check("s",    s,    m_s);
         check("busy", busy, m_busy);
         check("g",    g,    m_gnt & {4{a[m_s]}});
      end
   end

   task automatic edge_step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] want;
      logic [3:0] er_gnt [7];
      logic       er_busy [7];
      er_gnt  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
      er_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset held with all requests pending
      rst = 1'b1; req = 4'b1111; a = 4'b1111;
      edge_step();
      edge_step();
      check("rst_gnt", gnt, 4'b0000);
      check("rst_s", s, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_g", g, 4'b0000);
      check("rst_model_gnt", m_gnt, 4'b0000);
      rst = 1'b0;

      // Full contention: 0001,0010,0100,1000,0001 each 4 cycles, one dead cycle between
      for (int e = 1; e <= 21; e++) begin
         edge_step();
         want = ((e - 1) % 5 == 4) ? 4'b0000 : 4'(1 << (((e - 1) / 5) % 4));
         check("cont_gnt", gnt, want);
         check("cont_model_gnt", m_gnt, want);
         if (want != 4'b0000) check("cont_s", s, ((e - 1) / 5) % 4);
      end

      // Reset during second cycle of owner 2's grant
      for (int i = 0; i < 40 && gnt !== 4'b0100; i++) edge_step();
      check("mid_wait_owner2", gnt, 4'b0100);
      edge_step();
      rst = 1'b1;
      edge_step();
      check("mid_rst_gnt", gnt, 4'b0000);
      check("mid_rst_s", s, 2'b00);
      check("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      edge_step();
      check("mid_first_gnt", gnt, 4'b0001);
      check("mid_model_gnt", m_gnt, 4'b0001);

      // Single requester with data gating
      rst = 1'b1; req = 4'b0100; a = 4'b0000;
      edge_step();
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         edge_step();
         want = ((e - 1) % 5 == 4) ? 4'b0000 : 4'b0100;
         check("single_gnt", gnt, want);
         check("single_model_gnt", m_gnt, want);
         if (e == 1) begin
            check("single_s", s, 2'b10);
            a = 4'b0101; #1;
            check("gate_a0101", g, 4'b0100);
            a = 4'b1011; #1;
            check("gate_a1011", g, 4'b0000);
         end
         if (e == 5) begin
            a = 4'b1111; #1;
            check("gate_guard", g, 4'b0000);
         end
      end

      // Early release of requester 0, then everything drops
      rst = 1'b1; req = 4'b0011; a = 4'b0000;
      edge_step();
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         edge_step();
         check("early_gnt", gnt, er_gnt[e - 1]);
         check("early_busy", busy, er_busy[e - 1]);
         check("early_model_gnt", m_gnt, er_gnt[e - 1]);
         if (e == 3) req = 4'b0010;
         if (e == 5) req = 4'b0000;
      end

      // Randomised traffic with occasional reset
      for (int i = 0; i < 2000; i++) begin
         edge_step();
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) != 0) req = 4'($urandom);
         a = 4'($urandom);
      end

      rst = 1'b0;
      edge_step();
      edge_step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
